// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl -- frame sequencer between uart_rx and sobel_applier.
// Parses a 4-byte header (width LE16, height LE16) and validates it.
// Forwards pixel bytes through a 1-entry skid register, tagged with
// start-of-line, end-of-line and end-of-frame markers.
// Counts Sobel output bytes and pulses frame_done once the frame is complete.
// Optional feature macro: SOBEL_CTRL_TIMEOUT_EN enables the inter-byte
// timeout (err[2]). When the macro is undefined, err[2] is constant 0.
module sobel_frame_ctrl #(
   parameter int MAX_W       = 640,
   parameter int MAX_H       = 480,
   parameter int MIN_DIM     = 3,
   parameter int BORDER      = 1,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_sol,
   output logic        pix_eol,
   output logic        pix_eof,
   input  logic        sob_valid,
   output logic [15:0] frame_width,
   output logic [15:0] frame_height,
   output logic        busy,
   output logic        frame_done,
   output logic [2:0]  err,
   input  logic        clear_err
);

   localparam logic [15:0] MAX_W_C   = 16'(MAX_W);
   localparam logic [15:0] MAX_H_C   = 16'(MAX_H);
   localparam logic [15:0] MIN_DIM_C = 16'(MIN_DIM);
   localparam logic [15:0] BORDER2_C = 16'(2 * BORDER);

   typedef enum logic [1:0] {
      ST_HDR    = 2'd0,
      ST_CHECK  = 2'd1,
      ST_PIXELS = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_s;

   logic [1:0]  hdr_idx_r;
   logic [15:0] hdr_w_r;
   logic [15:0] hdr_h_r;
   logic [15:0] frame_width_r;
   logic [15:0] frame_height_r;
   logic [31:0] expected_r;
   logic [15:0] col_r;
   logic [15:0] row_r;
   logic [31:0] out_cnt_r;
   logic [7:0]  skid_data_r;
   logic        skid_valid_r;
   logic        busy_r;
   logic        done_r;
   logic [2:0]  err_r;

   logic        hdr_wr_s;
   logic        dims_bad_s;
   logic [15:0] inner_w_s;
   logic [15:0] inner_h_s;
   logic [31:0] expected_s;
   logic        xfer_s;
   logic        eol_s;
   logic        eof_s;
   logic        load_s;
   logic        ovf_s;
   logic        skid_set_s;
   logic        count_out_s;
   logic        start_frame_s;
   logic        bad_hdr_s;
   logic        frame_end_s;
   logic        busy_set_s;
   logic        tmo_s;

   // Header, skid and marker decode shared by the FSM and the datapath.
   always_comb begin
      hdr_wr_s    = (state_r == ST_HDR) && rx_valid;
      dims_bad_s  = (hdr_w_r < MIN_DIM_C) || (hdr_w_r > MAX_W_C) ||
                    (hdr_h_r < MIN_DIM_C) || (hdr_h_r > MAX_H_C);
      inner_w_s   = hdr_w_r - BORDER2_C;
      inner_h_s   = hdr_h_r - BORDER2_C;
      expected_s  = {16'd0, inner_w_s} * {16'd0, inner_h_s};
      xfer_s      = (state_r == ST_PIXELS) && skid_valid_r && pix_ready;
      eol_s       = (col_r == (frame_width_r - 16'd1));
      eof_s       = eol_s && (row_r == (frame_height_r - 16'd1));
      // The byte after the final pixel belongs to no frame and is not stored.
      load_s      = rx_valid && ((state_r == ST_CHECK) ||
                    ((state_r == ST_PIXELS) && !(xfer_s && eof_s)));
      ovf_s       = (state_r == ST_PIXELS) && rx_valid && skid_valid_r && !xfer_s;
      skid_set_s  = load_s && !ovf_s;
      count_out_s = sob_valid && ((state_r == ST_PIXELS) || (state_r == ST_DRAIN)) &&
                    (out_cnt_r != expected_r);
   end

`ifdef SOBEL_CTRL_TIMEOUT_EN
   localparam logic [31:0] TMO_LAST_C = 32'(TIMEOUT_CYC - 1);

   logic [31:0] tmo_cnt_r;
   logic        tmo_active_s;

   // Timeout is armed mid-header and while pixels are expected.
   always_comb begin
      tmo_active_s = ((state_r == ST_HDR) && (hdr_idx_r != 2'd0)) ||
                     (state_r == ST_PIXELS);
      tmo_s        = tmo_active_s && !rx_valid && (tmo_cnt_r == TMO_LAST_C);
   end

   // Idle-cycle counter, restarted by every received byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_r <= 32'd0;
      end else if (!tmo_active_s || rx_valid || tmo_s) begin
         tmo_cnt_r <= 32'd0;
      end else begin
         tmo_cnt_r <= tmo_cnt_r + 32'd1;
      end
   end
`else
   assign tmo_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_HDR;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic and single-cycle control strobes.
   always_comb begin
      state_s       = state_r;
      start_frame_s = 1'b0;
      bad_hdr_s     = 1'b0;
      frame_end_s   = 1'b0;
      busy_set_s    = 1'b0;
      case (state_r)
         ST_HDR: begin
            if (rx_valid) begin
               busy_set_s = (hdr_idx_r == 2'd0);
               if (hdr_idx_r == 2'd3) begin
                  state_s = ST_CHECK;
               end else begin
                  state_s = ST_HDR;
               end
            end else begin
               state_s = ST_HDR;
            end
         end
         ST_CHECK: begin
            if (dims_bad_s) begin
               bad_hdr_s = 1'b1;
               state_s   = ST_HDR;
            end else begin
               start_frame_s = 1'b1;
               state_s       = ST_PIXELS;
            end
         end
         ST_PIXELS: begin
            if (xfer_s && eof_s) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_PIXELS;
            end
         end
         ST_DRAIN: begin
            if (out_cnt_r == expected_r) begin
               frame_end_s = 1'b1;
               state_s     = ST_HDR;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_HDR;
         end
      endcase
      // A timeout abandons the frame from any armed state.
      if (tmo_s) begin
         state_s    = ST_HDR;
         busy_set_s = 1'b0;
      end else begin
         state_s = state_s;
      end
   end

   // Header byte capture, little-endian width then height.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hdr_idx_r <= 2'd0;
         hdr_w_r   <= 16'd0;
         hdr_h_r   <= 16'd0;
      end else if (tmo_s) begin
         hdr_idx_r <= 2'd0;
      end else if (hdr_wr_s) begin
         hdr_idx_r <= hdr_idx_r + 2'd1;
         case (hdr_idx_r)
            2'd0:    hdr_w_r[7:0]  <= rx_data;
            2'd1:    hdr_w_r[15:8] <= rx_data;
            2'd2:    hdr_h_r[7:0]  <= rx_data;
            2'd3:    hdr_h_r[15:8] <= rx_data;
            default: hdr_idx_r     <= 2'd0;
         endcase
      end
   end

   // Frame geometry and expected output count, latched once the header checks out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_width_r  <= 16'd0;
         frame_height_r <= 16'd0;
         expected_r     <= 32'd0;
      end else if (start_frame_s) begin
         frame_width_r  <= hdr_w_r;
         frame_height_r <= hdr_h_r;
         expected_r     <= expected_s;
      end
   end

   // Skid register: loads on rx_valid, empties on transfer, drops on abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_data_r  <= 8'd0;
         skid_valid_r <= 1'b0;
      end else if (bad_hdr_s || tmo_s) begin
         skid_valid_r <= 1'b0;
      end else if (skid_set_s) begin
         skid_data_r  <= rx_data;
         skid_valid_r <= 1'b1;
      end else if (xfer_s) begin
         skid_valid_r <= 1'b0;
      end
   end

   // Column/row position of the skid entry and saturating output count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_r     <= 16'd0;
         row_r     <= 16'd0;
         out_cnt_r <= 32'd0;
      end else if (start_frame_s) begin
         col_r     <= 16'd0;
         row_r     <= 16'd0;
         out_cnt_r <= 32'd0;
      end else begin
         if (xfer_s) begin
            if (eol_s) begin
               col_r <= 16'd0;
               row_r <= row_r + 16'd1;
            end else begin
               col_r <= col_r + 16'd1;
            end
         end
         if (count_out_s) begin
            out_cnt_r <= out_cnt_r + 32'd1;
         end
      end
   end

   // Busy flag, completion pulse and sticky error bits (clear wins over set).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         err_r  <= 3'b000;
      end else begin
         done_r <= frame_end_s;
         if (bad_hdr_s || frame_end_s || tmo_s) begin
            busy_r <= 1'b0;
         end else if (busy_set_s) begin
            busy_r <= 1'b1;
         end
         if (clear_err) begin
            err_r <= 3'b000;
         end else begin
            err_r <= err_r | {tmo_s, ovf_s, bad_hdr_s};
         end
      end
   end

   assign pix_data     = skid_data_r;
   assign pix_valid    = skid_valid_r;
   assign pix_sol      = skid_valid_r && (col_r == 16'd0);
   assign pix_eol      = skid_valid_r && eol_s;
   assign pix_eof      = skid_valid_r && eof_s;
   assign frame_width  = frame_width_r;
   assign frame_height = frame_height_r;
   assign busy         = busy_r;
   assign frame_done   = done_r;
   assign err          = err_r;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl: table of frame headers plus
// hand-written overflow, pass-through, idle and mid-frame reset sequences.
// Pixel outputs are checked against a scoreboard queue filled as bytes are sent.
module tb_sobel_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_sol;
   logic        pix_eol;
   logic        pix_eof;
   logic        sob_valid;
   logic [15:0] frame_width;
   logic [15:0] frame_height;
   logic        busy;
   logic        frame_done;
   logic [2:0]  err;
   logic        clear_err;

   typedef struct packed {
      logic [7:0] d;
      logic       sol;
      logic       eol;
      logic       eof;
   } pix_t;

   typedef struct {
      int w;
      int h;
      bit bad;
      bit early;
   } vec_t;

   pix_t exp_q[$];
   vec_t vecs[9];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   done_cnt = 0;

   sobel_frame_ctrl dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_eof(pix_eof),
      .sob_valid(sob_valid),
      .frame_width(frame_width), .frame_height(frame_height),
      .busy(busy), .frame_done(frame_done),
      .err(err), .clear_err(clear_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [7:0] pdata(input int i);
      return 8'((i * 7 + 3) % 256);
   endfunction

   // One clock: monitor at the falling edge, return just after the rising edge.
   task automatic tick();
      pix_t e;
      @(negedge clk);
      if (pix_valid && pix_ready) begin
         if (exp_q.size() == 0) begin
            chk("pix_unexpected", 32'({pix_data, pix_sol, pix_eol, pix_eof}), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("pixel", 32'({pix_data, pix_sol, pix_eol, pix_eof}), 32'(e));
         end
      end
      if (frame_done) done_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_hdr(input int w, input int h);
      send_byte(8'(w));
      send_byte(8'(w >> 8));
      send_byte(8'(h));
      send_byte(8'(h >> 8));
   endtask

   task automatic push_pix(input int w, input int h, input int i);
      pix_t p;
      p.d   = pdata(i);
      p.sol = ((i % w) == 0);
      p.eol = ((i % w) == (w - 1));
      p.eof = (i == (w * h - 1));
      exp_q.push_back(p);
   endtask

   task automatic send_pixels(input int w, input int h, input int from, input int upto,
                              input int sob_at);
      for (int i = from; i < upto; i++) begin
         push_pix(w, h, i);
         sob_valid = (i == sob_at);
         send_byte(pdata(i));
         sob_valid = 1'b0;
      end
   endtask

   task automatic finish_frame(input int w, input int h, input bit early);
      int nsob;
      int done0;
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      done0 = done_cnt;
      nsob  = (w - 2) * (h - 2) - (early ? 1 : 0);
      if (nsob > 0) begin
         for (int k = 0; k < nsob - 1; k++) begin
            sob_valid = 1'b1;
            tick();
            sob_valid = 1'b0;
         end
         tick(); tick(); tick();
         chk("no_early_done", 32'(done_cnt), 32'(done0));
         sob_valid = 1'b1;
         tick();
         sob_valid = 1'b0;
      end
      for (int k = 0; k < 8 && done_cnt == done0; k++) tick();
      tick(); tick();
      chk("frame_done_once", 32'(done_cnt), 32'(done0 + 1));
      chk("busy_after_done", 32'(busy), 32'd0);
   endtask

   task automatic run_frame(input vec_t v);
      send_hdr(v.w, v.h);
      if (v.bad) begin
         tick();
         chk("bad_dim_err", 32'(err), 32'd1);
         chk("bad_dim_busy", 32'(busy), 32'd0);
         clear_err = 1'b1;
         tick();
         clear_err = 1'b0;
         chk("clear_err", 32'(err), 32'd0);
      end else begin
         // First pixel arrives while the header is being checked.
         send_pixels(v.w, v.h, 0, 1, -1);
         chk("frame_width", 32'(frame_width), 32'(v.w));
         chk("frame_height", 32'(frame_height), 32'(v.h));
         chk("busy_in_frame", 32'(busy), 32'd1);
         send_pixels(v.w, v.h, 1, v.w * v.h, v.early ? (v.w * v.h - 2) : -1);
         finish_frame(v.w, v.h, v.early);
         chk("err_clean", 32'(err), 32'd0);
      end
   endtask

   initial begin
      vecs[0] = '{w: 8,   h: 8,   bad: 1'b0, early: 1'b0};
      vecs[1] = '{w: 2,   h: 8,   bad: 1'b1, early: 1'b0};
      vecs[2] = '{w: 16,  h: 16,  bad: 1'b0, early: 1'b0};
      vecs[3] = '{w: 8,   h: 2,   bad: 1'b1, early: 1'b0};
      vecs[4] = '{w: 641, h: 4,   bad: 1'b1, early: 1'b0};
      vecs[5] = '{w: 4,   h: 481, bad: 1'b1, early: 1'b0};
      vecs[6] = '{w: 3,   h: 3,   bad: 1'b0, early: 1'b1};
      vecs[7] = '{w: 640, h: 3,   bad: 1'b0, early: 1'b0};
      vecs[8] = '{w: 3,   h: 480, bad: 1'b0, early: 1'b0};

      rst = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; pix_ready = 1'b1;
      sob_valid = 1'b0; clear_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_markers", 32'({pix_sol, pix_eol, pix_eof}), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_width", 32'(frame_width), 32'd0);
      rst = 1'b0;
      tick();

      for (int v = 0; v < 9; v++) run_frame(vecs[v]);

      // Skid full, not draining: second byte dropped, overflow flagged.
      pix_ready = 1'b0;
      send_hdr(8, 8);
      tick();
      push_pix(8, 8, 0);
      send_byte(pdata(0));
      send_byte(8'hEE);
      chk("ovf_err", 32'(err), 32'd2);
      chk("ovf_held", 32'({pix_valid, pix_data}), 32'({1'b1, pdata(0)}));
      pix_ready = 1'b1;
      tick();
      send_pixels(8, 8, 1, 64, -1);
      finish_frame(8, 8, 1'b0);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("ovf_clear", 32'(err), 32'd0);

      // Load and drain in the same cycle with the skid full.
      pix_ready = 1'b0;
      send_hdr(8, 8);
      tick();
      push_pix(8, 8, 0);
      send_byte(pdata(0));
      pix_ready = 1'b1;
      push_pix(8, 8, 1);
      send_byte(pdata(1));
      chk("passthru_no_ovf", 32'(err), 32'd0);
      send_pixels(8, 8, 2, 64, -1);
      finish_frame(8, 8, 1'b0);

      // Partial frame then idle: no timeout in this build, stays busy.
      send_hdr(8, 8);
      send_pixels(8, 8, 0, 48, -1);
      repeat (200) tick();
      chk("idle_busy", 32'(busy), 32'd1);
      chk("idle_err", 32'(err), 32'd0);
      chk("idle_drained", 32'(exp_q.size()), 32'd0);

      // Mid-frame reset at pixel 20 of a 16x16 frame.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      tick();
      send_hdr(16, 16);
      send_pixels(16, 16, 0, 20, -1);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_pix_valid", 32'(pix_valid), 32'd0);
      chk("arst_geom", 32'({frame_width, frame_height}), 32'd0);
      chk("arst_err_done", 32'({err, frame_done}), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      run_frame(vecs[2]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
Frame sequencer between uart_rx and sobel_applier. Parses the 4-byte frame header (width LE16, height LE16), validates dimensions, then forwards pixel bytes to the Sobel datapath through a 1-entry skid register, tagged with start-of-line, end-of-line and end-of-frame markers. Counts Sobel output bytes and signals frame completion. Reports header, overflow and (optional) timeout errors.

Parameters:
MAX_W, 640, maximum accepted frame width (pixels); must fit in 16 bits
MAX_H, 480, maximum accepted frame height (lines); must fit in 16 bits
MIN_DIM, 3, minimum accepted width and height
BORDER, 1, pixels lost per edge by the kernel; expected outputs = (W-2*BORDER)*(H-2*BORDER)
TIMEOUT_CYC, 1000000, inter-byte gap limit in clk cycles (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
rx_data  in  8  byte from uart_rx
rx_valid  in  1  1-cycle strobe, rx_data valid; cannot be back-pressured
pix_data  out  8  pixel to sobel_applier
pix_valid  out  1  pixel valid
pix_ready  in  1  sobel_applier accepts pixel when pix_valid&pix_ready
pix_sol  out  1  pixel is column 0
pix_eol  out  1  pixel is column W-1
pix_eof  out  1  pixel is the last pixel of the frame
sob_valid  in  1  sobel_applier output byte transferred (1-cycle strobe per byte)
frame_width  out  16  latched width, valid while busy
frame_height  out  16  latched height, valid while busy
busy  out  1  high from header byte 0 accepted until frame_done
frame_done  out  1  1-cycle pulse when all expected outputs are counted
err  out  3  sticky: [0] bad dimensions, [1] skid overflow, [2] timeout
clear_err  in  1  synchronous clear of err (has priority over setting in same cycle)

Behaviour:
- Reset: state HDR, hdr_idx=0, all outputs 0, skid empty, counters 0.
- States: HDR, CHECK, PIXELS, DRAIN.
- HDR: each rx_valid stores byte hdr_idx (0=W lo, 1=W hi, 2=H lo, 3=H hi); busy rises on byte 0. After byte 3 -> CHECK. sob_valid ignored.
- CHECK (1 cycle): if W<MIN_DIM, W>MAX_W, H<MIN_DIM or H>MAX_H: set err[0], busy<=0, -> HDR. Else latch frame_width/height, compute expected = (W-2*BORDER)*(H-2*BORDER) as 32-bit unsigned, clear col/row/out counters -> PIXELS. An rx_valid during CHECK is held in the skid register and consumed as the first pixel.
- PIXELS: rx_valid loads skid (pix_valid=1 the next cycle). Skid cleared on pix_valid&pix_ready; load and drain in the same cycle is legal (pass-through, no overflow). rx_valid while skid full and not draining: byte dropped, err[1] set, counters not advanced.
- Markers combinational from col/row of the skid entry: pix_sol=(col==0), pix_eol=(col==W-1), pix_eof=pix_eol&(row==H-1). On transfer col increments, wraps to 0 at W-1 with row increment. Transfer with pix_eof -> DRAIN.
- sob_valid counted in PIXELS and DRAIN (16-bit counters, 32-bit out count, saturating).
- DRAIN: rx_valid bytes ignored. When out_count==expected: frame_done=1 for one cycle, busy<=0, -> HDR. If expected==0 cannot occur (MIN_DIM>2*BORDER required).
- Output counting beyond expected has no effect; out count reaching expected while still in PIXELS is held and frame_done fires on DRAIN entry cycle+1.
- Reset mid-frame: immediate return to reset values; any partial frame discarded.

Optional Feature:
SOBEL_CTRL_TIMEOUT_EN: when defined, a cycle counter restarts on every rx_valid while state is HDR (hdr_idx>0) or PIXELS; reaching TIMEOUT_CYC sets err[2], drops skid, busy<=0, returns to HDR with hdr_idx=0. Without it, the controller waits indefinitely and err[2] is constant 0.

Test Plan:
- Header 08 00 08 00, 64 pixels 0..63, pix_ready=1, sob_valid pulsed 36 times -> frame_width=8, height=8; pix_sol on pixels 0,8,..,56; pix_eol on 7,15,..,63; pix_eof only on 63; frame_done one pulse after 36th sob_valid; busy 0.
- Header 02 00 08 00 -> err=3'b001, busy 0, next header 10 00 10 00 accepted (W=H=16, expected=196).
- pix_ready held 0 for two rx_valid pixel bytes -> first held, second dropped, err[1]=1; col advances only by 1 after ready returns.
- rx_valid same cycle as pix_ready drain with skid full -> no overflow, both bytes transferred in order.
- Header 08 00 08 00, 48 pixels then idle: with SOBEL_CTRL_TIMEOUT_EN and TIMEOUT_CYC=1000 -> err[2]=1 after 1000 idle cycles, HDR state; without macro -> busy stays 1.
- rst asserted mid-PIXELS (pixel 20) -> all outputs 0 asynchronously; after release, fresh 16x16 frame of 256 bytes completes with frame_done after 196 sob_valid; clear_err clears err the cycle after assertion.
